// File: rtl/enc_pkg.sv
// Shared definitions for the serial set-bit index encoder:
// default sizes, FSM state encoding and a population-count helper.
package enc_pkg;

    localparam int N_DEF     = 8;
    localparam int IDX_W_DEF = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Works for any vector up to 64 bits; callers zero-extend their operand.
    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            c += 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/eightxthree_prio_encoder.sv
// Combinational priority encoder: index of the lowest (or highest) set bit,
// plus all-zero and exactly-one-bit flags.
module eightxthree_prio_encoder #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     vec,
    input  logic             msb_first,
    output logic [IDX_W-1:0] idx,
    output logic             none,
    output logic             single
);

    always_comb begin
        // NOTE: every output is given a default before the loop, so no path leaves it unassigned and no latch is inferred.
        idx    = '0;
        none   = (vec == '0);
        single = !none && ((vec & (vec - N'(1))) == '0);
        if (msb_first) begin
            // Ascending scan: the last hit is the highest set bit.
            for (int i = 0; i < N; i++) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/eightxthree_seq_encoder.sv
// Captures a request vector and serially emits the index of every set bit,
// one beat per valid/ready handshake, then returns to accepting vectors.
module eightxthree_seq_encoder
    import enc_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int IDX_W     = IDX_W_DEF,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none,
    output logic [IDX_W:0]   out_count
);

    if (N < 2 || (N & (N - 1)) != 0 || IDX_W != $clog2(N)) begin : g_bad_params
        $error("eightxthree_seq_encoder: N must be a power of two >= 2 and IDX_W == log2(N)");
    end

    state_t           state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [IDX_W:0]   count_q, count_d;

    logic [IDX_W-1:0] enc_idx;
    logic             enc_none;
    logic             enc_single;

    eightxthree_prio_encoder #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_prio (
        .vec       (pending_q),
        .msb_first (MSB_FIRST),
        .idx       (enc_idx),
        .none      (enc_none),
        .single    (enc_single)
    );

    // Outputs decode straight from the state register, so an asynchronous
    // reset drops out_valid without waiting for a clock edge.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_EMIT);
        out_idx   = out_valid ? enc_idx : '0;
        out_none  = out_valid && enc_none;
        out_last  = out_valid && (enc_none || enc_single);
        out_count = count_q;
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    pending_d = in_vec;
                    count_d   = (IDX_W + 1)'(popcount(64'(in_vec)));
                    state_d   = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (out_last) begin
                        pending_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        pending_d = pending_q & ~(N'(1) << enc_idx);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_eightxthree_seq_encoder.sv
// Self-checking bench: LSB-first and MSB-first instances run side by side
// against a queue-based model of the expected index sequence.
module tb_eightxthree_seq_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_vec = 8'h00;
    logic       out_ready = 1'b0;

    logic       in_ready_lo, out_valid_lo, out_last_lo, out_none_lo;
    logic [2:0] out_idx_lo;
    logic [3:0] out_count_lo;
    logic       in_ready_hi, out_valid_hi, out_last_hi, out_none_hi;
    logic [2:0] out_idx_hi;
    logic [3:0] out_count_hi;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    eightxthree_seq_encoder #(.N(8), .IDX_W(3), .MSB_FIRST(1'b0)) dut_lo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_lo),
        .in_vec    (in_vec),
        .out_valid (out_valid_lo),
        .out_ready (out_ready),
        .out_idx   (out_idx_lo),
        .out_last  (out_last_lo),
        .out_none  (out_none_lo),
        .out_count (out_count_lo)
    );

    eightxthree_seq_encoder #(.N(8), .IDX_W(3), .MSB_FIRST(1'b1)) dut_hi (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_hi),
        .in_vec    (in_vec),
        .out_valid (out_valid_hi),
        .out_ready (out_ready),
        .out_idx   (out_idx_hi),
        .out_last  (out_last_hi),
        .out_none  (out_none_hi),
        .out_count (out_count_hi)
    );

    task automatic check(input string tag, input int unsigned observed, input int unsigned expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: out_ready held high; 1: toggles 1,0,1,0...; 2: random.
    // hold: keep in_valid high with a changing in_vec throughout the burst.
    task automatic run_burst(input logic [7:0] vec, input int mode, input bit hold);
        int unsigned exp_lo[$];
        int unsigned exp_hi[$];
        int unsigned pc;
        int unsigned beats;
        int unsigned lasts;
        int          cyc;
        bit          rdy;
        bit          is_none;

        pc = 0;
        for (int i = 0; i < 8; i++) begin
            if (vec[i]) begin
                exp_lo.push_back(i);
                exp_hi.push_front(i);
                pc++;
            end
        end
        is_none = (pc == 0);
        if (is_none) begin
            exp_lo.push_back(0);
            exp_hi.push_back(0);
        end

        check("pre_accept_in_ready_lo", in_ready_lo, 1);
        check("pre_accept_in_ready_hi", in_ready_hi, 1);
        in_valid  = 1'b1;
        in_vec    = vec;
        out_ready = 1'b0;
        tick();

        beats = 0;
        lasts = 0;
        cyc   = 0;
        while (exp_lo.size() > 0 && cyc < 64) begin
            if (hold) begin
                in_valid = 1'b1;
                in_vec   = 8'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;

            check("valid_lo", out_valid_lo, 1);
            check("valid_hi", out_valid_hi, 1);
            check("in_ready_lo_busy", in_ready_lo, 0);
            check("in_ready_hi_busy", in_ready_hi, 0);
            check("idx_lo", out_idx_lo, exp_lo[0]);
            check("idx_hi", out_idx_hi, exp_hi[0]);
            check("last_lo", out_last_lo, (exp_lo.size() == 1) ? 1 : 0);
            check("last_hi", out_last_hi, (exp_hi.size() == 1) ? 1 : 0);
            check("none_lo", out_none_lo, is_none ? 1 : 0);
            check("none_hi", out_none_hi, is_none ? 1 : 0);
            check("count_lo", out_count_lo, pc);
            check("count_hi", out_count_hi, pc);

            if (rdy) begin
                beats++;
                if (exp_lo.size() == 1) lasts++;
            end
            tick();
            if (rdy) begin
                void'(exp_lo.pop_front());
                void'(exp_hi.pop_front());
            end
            cyc++;
        end
        in_valid = 1'b0;

        check("burst_timeout_remaining", exp_lo.size(), 0);
        check("burst_beats", beats, (pc == 0) ? 1 : pc);
        check("burst_last_beats", lasts, 1);
        check("bubble_in_ready_lo", in_ready_lo, 1);
        check("bubble_in_ready_hi", in_ready_hi, 1);
        check("bubble_valid_lo", out_valid_lo, 0);
        check("bubble_count_held", out_count_lo, pc);
    endtask

    initial begin
        #2;
        check("reset_in_ready", in_ready_lo, 1);
        check("reset_out_valid", out_valid_lo, 0);
        check("reset_out_idx", out_idx_lo, 0);
        check("reset_out_last", out_last_lo, 0);
        check("reset_out_none", out_none_lo, 0);
        check("reset_out_count", out_count_lo, 0);
        check("reset_out_count_hi", out_count_hi, 0);
        tick();
        rst = 1'b0;
        tick();

        // Directed bursts: mixed bits, empty, full with stalls.
        run_burst(8'b1010_0100, 0, 1'b0);
        run_burst(8'h00,        0, 1'b0);
        run_burst(8'hFF,        1, 1'b0);
        run_burst(8'b0000_0001, 0, 1'b0);
        run_burst(8'b1000_0000, 1, 1'b0);

        // Changing in_vec while busy must not disturb the captured burst.
        run_burst(8'b0110_1001, 0, 1'b1);

        // Asynchronous reset mid-burst: after the idx=0 beat, idx 4 is dropped.
        in_valid  = 1'b1;
        in_vec    = 8'b0001_0001;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("rst_mid_idx_lo", out_idx_lo, 0);
        check("rst_mid_valid_lo", out_valid_lo, 1);
        tick();
        check("rst_mid_idx4_lo", out_idx_lo, 4);
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_valid_lo", out_valid_lo, 0);
        check("rst_async_valid_hi", out_valid_hi, 0);
        check("rst_async_in_ready", in_ready_lo, 1);
        check("rst_async_count", out_count_lo, 0);
        #1;
        rst = 1'b0;
        run_burst(8'b1000_0000, 0, 1'b0);

        // Randomised vectors and backpressure.
        for (int k = 0; k < 20; k++) begin
            run_burst(8'($urandom), 2, k[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/eightxthree_seq_encoder.md
Name: eightxthree_seq_encoder

Overview:
- Inverse of the 3-to-8 one-hot decoder.
- Accepts an 8-bit request vector and serially emits the 3-bit index of every set bit, one beat per handshake.
- Order is ascending by default.
- Sits between the matrix multiplier's element-select/enable logic and the index-driven operand fetch. The fetch side can then walk active lanes without scanning them itself.

Parameters:
N, 8, request vector width; must be a power of two, minimum 2.
IDX_W, 3, index width; must equal log2(N).
MSB_FIRST, 0, 0 = emit lowest set bit first; 1 = emit highest set bit first.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  request vector present.
in_ready  output  1  block can accept a vector (IDLE only).
in_vec  input  N  request vector; bit k set means index k is pending.
out_valid  output  1  out_idx/out_last/out_none are valid.
out_ready  input  1  consumer takes the current beat.
out_idx  output  IDX_W  index of the current set bit.
out_last  output  1  current beat is the final beat for this vector.
out_none  output  1  captured vector was all-zero; beat carries no index.
out_count  output  IDX_W+1  population count of the captured vector; held for the whole burst.

Behaviour:
- States are IDLE and EMIT. Internal registers: pending[N-1:0], count[IDX_W:0].
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, pending=0, count=0.
  - Outputs: in_ready=1, out_valid=0, out_idx=0, out_last=0, out_none=0, out_count=0.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready at a clock edge: pending<=in_vec, count<=popcount(in_vec), state<=EMIT.
- EMIT outputs:
  - in_ready=0 and out_valid=1.
  - Latency from the accept edge to the first out_valid is 1 cycle.
  - out_idx is the priority encode of pending: lowest set bit if MSB_FIRST=0, highest if 1.
  - out_last=1 when pending has exactly one bit set, or when pending==0.
  - out_none=1 iff pending==0, which happens only when the accepted vector was zero. In that case out_idx=0, out_last=1, out_count=0.
- EMIT beat handling:
  - Outputs are stable while out_valid&&!out_ready. in_vec is ignored in EMIT.
  - On out_valid&&out_ready: clear bit out_idx in pending.
    - If out_last: state<=IDLE, pending<=0. count is retained until the next accept.
    - Otherwise stay in EMIT; the next index appears on the following cycle.
  - Back-to-back throughput is 1 index per cycle while out_ready stays high.
- Burst length is always max(popcount,1) beats. Exactly one beat per burst has out_last=1.
- Between bursts there is one mandatory bubble: in_ready rises the cycle after the last beat. No same-cycle re-accept.
- Reset mid-burst: remaining indices are dropped and out_valid falls asynchronously. After release, the first edge may accept a new vector.
- Out-of-range indices cannot occur, because IDX_W=log2(N) is enforced.
- out_count width IDX_W+1 holds N (value 8 for an all-ones vector).

Decomposition:
- Shared package enc_pkg:
  - Constants N_DEF=8, IDX_W_DEF=3.
  - State encoding ST_IDLE=1'b0, ST_EMIT=1'b1.
  - Popcount function.
- One natural sub-module, eightxthree_prio_encoder: combinational.
  - Inputs vec[N-1:0] and msb_first.
  - Outputs idx[IDX_W-1:0], none, single (exactly one bit set).
  - Reusable elsewhere as the combinational counterpart of threexeightdecoder.
- The top level holds state, pending, count and the handshake logic.

Test Plan:
- Reset, then in_vec=8'b1010_0100 with out_ready=1 held → out_idx 2,5,7 on consecutive cycles; out_last only on 7; out_count=3; in_ready returns 1 the cycle after the idx=7 beat.
- Same vector with MSB_FIRST=1 → out_idx 7,5,2; out_last on 2.
- in_vec=8'h00 → a single beat with out_none=1, out_idx=0, out_last=1, out_count=0.
- in_vec=8'hFF with out_ready toggling 1,0,1,0… → indices 0..7 in order, each held stable while out_ready=0, no index lost or duplicated; out_count=8; 8 beats total.
- in_vec=8'b0001_0001, then rst pulsed asynchronously between clock edges after the idx=0 beat → out_valid drops immediately, in_ready=1, idx 4 is never emitted; next vector 8'b1000_0000 yields a single beat idx=7.
- Hold in_valid=1 with a changing in_vec during EMIT → in_ready=0 and the burst reflects only the vector captured at accept.
